// File: rtl/triangle_burst_gate_pkg.sv
// Shared types and default sizing for the triangle burst gate.
package triangle_burst_gate_pkg;

  localparam int unsigned DEF_CHANNELS         = 8;
  localparam int unsigned DEF_PARALLEL_SAMPLES = 16;
  localparam int unsigned DEF_SAMPLE_WIDTH     = 16;
  localparam int unsigned DEF_COUNT_BITS       = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    BURST = 2'd2
  } burst_state_t;

endpackage

// File: rtl/triangle_burst_gate_channel.sv
// One channel's burst FSM: counts trigger-delimited periods and decides which batches pass.
module triangle_burst_gate_channel
  import triangle_burst_gate_pkg::*;
#(
  parameter int unsigned COUNT_W = DEF_COUNT_BITS
) (
  input  logic               dac_clk,
  input  logic               dac_reset_n,
  input  logic               arm_i,
  input  logic               abort_i,
  input  logic               trigger_i,
  input  logic               valid_i,
  input  logic [COUNT_W-1:0] n_cfg_i,
  output logic               pass_c_o,
  output logic               busy_o,
  output logic               done_o
);

  burst_state_t       state_q;
  logic [COUNT_W-1:0] cnt_q;
  logic [COUNT_W-1:0] n_cur_q;
  logic               busy_q;
  logic               done_q;

  logic               qual_c;
  logic               ending_c;
  logic [COUNT_W-1:0] cnt_inc_c;

  // The trigger that closes the last period starts period N+1, so that batch is withheld.
  assign qual_c    = trigger_i & valid_i;
  assign cnt_inc_c = cnt_q + COUNT_W'(1);
  assign ending_c  = (state_q == BURST) & qual_c & (cnt_inc_c == n_cur_q);
  assign pass_c_o  = ((state_q == BURST) & ~ending_c) | ((state_q == ARMED) & qual_c);

  always_ff @(posedge dac_clk or negedge dac_reset_n) begin
    if (!dac_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_cur_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_i) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (arm_i && (n_cfg_i != '0)) begin
              state_q <= ARMED;
              n_cur_q <= n_cfg_i;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
          ARMED: begin
            if (qual_c) state_q <= BURST;
          end
          BURST: begin
            if (qual_c) begin
              cnt_q <= cnt_inc_c;
              if (ending_c) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: rtl/triangle_burst_gate.sv
// Gates a parallel triangle sample stream so each channel emits exactly N whole periods per arm.
module triangle_burst_gate
  import triangle_burst_gate_pkg::*;
#(
  parameter int unsigned CHANNELS         = DEF_CHANNELS,
  parameter int unsigned PARALLEL_SAMPLES = DEF_PARALLEL_SAMPLES,
  parameter int unsigned SAMPLE_WIDTH     = DEF_SAMPLE_WIDTH,
  parameter int unsigned COUNT_BITS       = DEF_COUNT_BITS
) (
  input  logic                                            dac_clk,
  input  logic                                            dac_reset_n,
  input  logic [CHANNELS*COUNT_BITS-1:0]                  cfg_data,
  input  logic                                            cfg_valid,
  output logic                                            cfg_ready,
  input  logic [CHANNELS-1:0]                             arm,
  input  logic [CHANNELS-1:0]                             abort,
  input  logic [CHANNELS*PARALLEL_SAMPLES*SAMPLE_WIDTH-1:0] data_in_data,
  input  logic [CHANNELS-1:0]                             data_in_valid,
  input  logic [CHANNELS-1:0]                             trigger_in,
  output logic [CHANNELS*PARALLEL_SAMPLES*SAMPLE_WIDTH-1:0] data_out_data,
  output logic [CHANNELS-1:0]                             data_out_valid,
  output logic [CHANNELS-1:0]                             trigger_out,
  output logic [CHANNELS-1:0]                             busy,
  output logic [CHANNELS-1:0]                             done
);

  localparam int unsigned BATCH_W = PARALLEL_SAMPLES * SAMPLE_WIDTH;

  logic [COUNT_BITS-1:0]         n_cfg_q [CHANNELS];
  logic [CHANNELS*BATCH_W-1:0]   data_out_q;
  logic [CHANNELS-1:0]           valid_out_q;
  logic [CHANNELS-1:0]           trig_out_q;
  logic [CHANNELS-1:0]           pass_c;

  assign cfg_ready = 1'b1;

  // Period count latch; a running burst keeps its own copy taken at arm time.
  always_ff @(posedge dac_clk or negedge dac_reset_n) begin
    if (!dac_reset_n) begin
      for (int ch = 0; ch < int'(CHANNELS); ch++) n_cfg_q[ch] <= '0;
    end else if (cfg_valid) begin
      for (int ch = 0; ch < int'(CHANNELS); ch++)
        n_cfg_q[ch] <= cfg_data[ch*COUNT_BITS +: COUNT_BITS];
    end
  end

  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_chan
    triangle_burst_gate_channel #(
      .COUNT_W (COUNT_BITS)
    ) u_chan (
      .dac_clk     (dac_clk),
      .dac_reset_n (dac_reset_n),
      .arm_i       (arm[g]),
      .abort_i     (abort[g]),
      .trigger_i   (trigger_in[g]),
      .valid_i     (data_in_valid[g]),
      .n_cfg_i     (n_cfg_q[g]),
      .pass_c_o    (pass_c[g]),
      .busy_o      (busy[g]),
      .done_o      (done[g])
    );
  end

  // Valid is never gated: zeroed batches are legitimate idle samples for the DAC.
  always_ff @(posedge dac_clk or negedge dac_reset_n) begin
    if (!dac_reset_n) begin
      data_out_q  <= '0;
      valid_out_q <= '0;
      trig_out_q  <= '0;
    end else begin
      valid_out_q <= data_in_valid;
      trig_out_q  <= trigger_in & pass_c;
      for (int ch = 0; ch < int'(CHANNELS); ch++)
        data_out_q[ch*BATCH_W +: BATCH_W] <= pass_c[ch] ? data_in_data[ch*BATCH_W +: BATCH_W]
                                                        : '0;
    end
  end

  assign data_out_data  = data_out_q;
  assign data_out_valid = valid_out_q;
  assign trigger_out    = trig_out_q;

endmodule

// File: tb/tb_triangle_burst_gate.sv
// Randomized bench for triangle_burst_gate against a trigger-counting reference model.
module tb_triangle_burst_gate;

  localparam int CH = 8;
  localparam int BW = 256;
  localparam int CB = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CH*CB-1:0]  cfg_data = '0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [CH-1:0]     arm = '0, abort = '0, trigger_in = '0, data_in_valid = '0;
  logic [CH*BW-1:0]  data_in_data = '0;
  logic [CH*BW-1:0]  data_out_data;
  logic [CH-1:0]     data_out_valid, trigger_out, busy, done;

  always #5 clk = ~clk;

  triangle_burst_gate dut (
    .dac_clk        (clk),
    .dac_reset_n    (rst_n),
    .cfg_data       (cfg_data),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .arm            (arm),
    .abort          (abort),
    .data_in_data   (data_in_data),
    .data_in_valid  (data_in_valid),
    .trigger_in     (trigger_in),
    .data_out_data  (data_out_data),
    .data_out_valid (data_out_valid),
    .trigger_out    (trigger_out),
    .busy           (busy),
    .done           (done)
  );

  // Reference model: a burst is "triggers counted since arm"; it passes from trigger 1 up to
  // (but excluding) trigger N+1.
  int               m_ncfg [CH];
  bit               m_active [CH];
  int               m_n [CH];
  int               m_trigs [CH];
  logic [CH*BW-1:0] exp_data;
  logic [CH-1:0]    exp_valid, exp_trig, exp_busy, exp_done;
  int               n_cmp = 0;
  int               n_fail = 0;

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_ncfg[c] = 0; m_active[c] = 0; m_n[c] = 0; m_trigs[c] = 0;
    end
    exp_data = '0; exp_valid = '0; exp_trig = '0; exp_busy = '0; exp_done = '0;
  endtask

  task automatic model_cycle();
    for (int c = 0; c < CH; c++) begin
      bit qual, pass, fin;
      qual = trigger_in[c] & data_in_valid[c];
      fin  = 0;
      if (!m_active[c]) pass = 0;
      else if (m_trigs[c] >= 1) pass = !(qual && m_trigs[c] == m_n[c]);
      else pass = qual;
      if (abort[c]) m_active[c] = 0;
      else if (!m_active[c]) begin
        if (arm[c] && m_ncfg[c] != 0) begin
          m_active[c] = 1; m_n[c] = m_ncfg[c]; m_trigs[c] = 0;
        end
      end else if (qual) begin
        m_trigs[c]++;
        if (m_trigs[c] == m_n[c] + 1) begin m_active[c] = 0; fin = 1; end
      end
      exp_data[c*BW +: BW] = pass ? data_in_data[c*BW +: BW] : '0;
      exp_trig[c] = trigger_in[c] & pass;
      exp_busy[c] = m_active[c];
      exp_done[c] = fin;
    end
    exp_valid = data_in_valid;
    if (cfg_valid)
      for (int c = 0; c < CH; c++) m_ncfg[c] = int'(cfg_data[c*CB +: CB]);
  endtask

  task automatic step(input logic [CH-1:0] a, input logic [CH-1:0] ab, input logic [CH-1:0] tr,
                      input logic [CH-1:0] va, input logic cv, input logic [CH*CB-1:0] cd);
    @(negedge clk);
    arm = a; abort = ab; trigger_in = tr; data_in_valid = va; cfg_valid = cv; cfg_data = cd;
    for (int w = 0; w < CH*BW/32; w++) data_in_data[w*32 +: 32] = $urandom();
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CH*CB-1:0] cfg_one(input int c, input int n);
    logic [CH*CB-1:0] v;
    v = '0;
    v[c*CB +: CB] = CB'(n);
    return v;
  endfunction

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({data_out_valid, trigger_out, busy, done} !== '0 || data_out_data !== '0) begin
      n_fail++;
      $display("FAIL reset: valid/trig/busy/done=%h/%h/%h/%h required 0", data_out_valid,
               trigger_out, busy, done);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int pulses = 0, dones = 0, passed = 0;
    step('0, '0, '0, '1, 1'b1, cfg_one(0, 2));
    step(8'h01, '0, '0, '1, 1'b0, '0);
    for (int c = 0; c < 40; c++) begin
      step('0, '0, (c % 8 == 3) ? 8'h01 : 8'h00, '1, 1'b0, '0);
      n_cmp++;
      if ({data_out_valid, trigger_out, busy, done} !== {exp_valid, exp_trig, exp_busy, exp_done}
          || data_out_data !== exp_data) begin
        n_fail++;
        $display("FAIL basic c%0d: trig/busy/done=%h/%h/%h required %h/%h/%h data_ok=%0d", c,
                 trigger_out, busy, done, exp_trig, exp_busy, exp_done, data_out_data === exp_data);
      end
      pulses += int'(trigger_out[0]);
      dones  += int'(done[0]);
      passed += int'(data_out_data[0 +: BW] != '0);
    end
    n_cmp++;
    if (passed != 16 || pulses != 2 || dones != 1 || busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_counts: passed/pulses/dones/busy=%0d/%0d/%0d/%b required 16/2/1/0",
               passed, pulses, dones, busy[0]);
    end
  endtask

  task automatic test_zero_cfg();
    step('0, '0, '0, '1, 1'b1, '0);
    step('1, '0, '0, '1, 1'b0, '0);
    for (int c = 0; c < 20; c++) begin
      step((c == 3) ? 8'hFF : 8'h00, '0, CH'($urandom()), '1, 1'b0, '0);
      n_cmp++;
      if (busy !== '0 || trigger_out !== '0 || data_out_data !== '0 || data_out_data !== exp_data
          || busy !== exp_busy) begin
        n_fail++;
        $display("FAIL zero_cfg c%0d: busy/trig=%h/%h required 0/0 data_zero=%0d", c, busy,
                 trigger_out, data_out_data == '0);
      end
    end
  endtask

  task automatic test_arm_trig_same();
    int passed = 0, dones = 0;
    step('0, '0, '0, '1, 1'b1, cfg_one(1, 1));
    step(8'h02, '0, 8'h02, '1, 1'b0, '0);
    n_cmp++;
    if (trigger_out[1] !== 1'b0 || busy[1] !== 1'b1 || data_out_data[BW +: BW] !== '0) begin
      n_fail++;
      $display("FAIL arm_trig_first: trig/busy=%b/%b required 0/1", trigger_out[1], busy[1]);
    end
    for (int c = 0; c < 12; c++) begin
      step('0, '0, (c == 3 || c == 7) ? 8'h02 : 8'h00, '1, 1'b0, '0);
      n_cmp++;
      if ({trigger_out, busy, done} !== {exp_trig, exp_busy, exp_done} || data_out_data !== exp_data) begin
        n_fail++;
        $display("FAIL arm_trig c%0d: trig/busy/done=%h/%h/%h required %h/%h/%h", c, trigger_out,
                 busy, done, exp_trig, exp_busy, exp_done);
      end
      passed += int'(data_out_data[BW +: BW] != '0);
      dones  += int'(done[1]);
    end
    n_cmp++;
    if (passed != 4 || dones != 1) begin
      n_fail++;
      $display("FAIL arm_trig_counts: passed/dones=%0d/%0d required 4/1", passed, dones);
    end
  endtask

  task automatic test_abort();
    int dones = 0;
    step('0, '0, '0, '1, 1'b1, cfg_one(2, 5));
    step(8'h04, '0, '0, '1, 1'b0, '0);
    for (int c = 0; c < 16; c++) begin
      step('0, (c == 6) ? 8'h04 : 8'h00, (c % 4 == 1) ? 8'h04 : 8'h00, '1, 1'b0, '0);
      n_cmp++;
      if ({trigger_out, busy, done} !== {exp_trig, exp_busy, exp_done} || data_out_data !== exp_data) begin
        n_fail++;
        $display("FAIL abort c%0d: trig/busy/done=%h/%h/%h required %h/%h/%h", c, trigger_out,
                 busy, done, exp_trig, exp_busy, exp_done);
      end
      dones += int'(done[2]);
      if (c == 7) begin
        n_cmp++;
        if (busy[2] !== 1'b0 || data_out_data[2*BW +: BW] !== '0) begin
          n_fail++;
          $display("FAIL abort_zero: busy=%b data_zero=%0d required 0/1", busy[2],
                   data_out_data[2*BW +: BW] == '0);
        end
      end
    end
    step(8'h04, '0, '0, '1, 1'b0, '0);
    n_cmp++;
    if (dones != 0 || busy[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_rearm: dones/busy=%0d/%b required 0/1", dones, busy[2]);
    end
    step('0, 8'h04, '0, '1, 1'b0, '0);
  endtask

  task automatic test_valid_gate();
    step('0, '0, '0, '1, 1'b1, cfg_one(3, 1));
    step(8'h08, '0, '0, '1, 1'b0, '0);
    step('0, '0, 8'h08, 8'hF7, 1'b0, '0);
    n_cmp++;
    if (data_out_data[3*BW +: BW] !== '0 || trigger_out[3] !== 1'b0 || busy[3] !== 1'b1
        || data_out_valid !== 8'hF7) begin
      n_fail++;
      $display("FAIL valid_hold: trig/busy/valid=%b/%b/%h required 0/1/f7", trigger_out[3],
               busy[3], data_out_valid);
    end
    step('0, '0, '0, '1, 1'b0, '0);
    step('0, '0, 8'h08, '1, 1'b0, '0);
    n_cmp++;
    if (data_out_data[3*BW +: BW] === '0 || trigger_out[3] !== 1'b1 || data_out_data !== exp_data) begin
      n_fail++;
      $display("FAIL valid_start: trig=%b data_zero=%0d required 1/0", trigger_out[3],
               data_out_data[3*BW +: BW] == '0);
    end
    step('0, '0, '0, '1, 1'b0, '0);
    step('0, '0, 8'h08, '1, 1'b0, '0);
    n_cmp++;
    if (done[3] !== 1'b1 || busy[3] !== 1'b0 || data_out_data[3*BW +: BW] !== '0) begin
      n_fail++;
      $display("FAIL valid_end: done/busy=%b/%b required 1/0", done[3], busy[3]);
    end
  endtask

  task automatic test_cfg_update();
    int pulses = 0, dones = 0;
    step('0, '0, '0, '1, 1'b1, cfg_one(4, 3));
    step(8'h10, '0, '0, '1, 1'b0, '0);
    for (int c = 0; c < 30; c++) begin
      step('0, '0, (c % 5 == 2) ? 8'h10 : 8'h00, '1, c == 8, (c == 8) ? cfg_one(4, 1) : '0);
      n_cmp++;
      if ({trigger_out, busy, done} !== {exp_trig, exp_busy, exp_done} || data_out_data !== exp_data) begin
        n_fail++;
        $display("FAIL cfg_upd c%0d: trig/busy/done=%h/%h/%h required %h/%h/%h", c, trigger_out,
                 busy, done, exp_trig, exp_busy, exp_done);
      end
      pulses += int'(trigger_out[4]);
      dones  += int'(done[4]);
    end
    n_cmp++;
    if (pulses != 3 || dones != 1) begin
      n_fail++;
      $display("FAIL cfg_old_n: pulses/dones=%0d/%0d required 3/1", pulses, dones);
    end
    pulses = 0; dones = 0;
    step(8'h10, '0, '0, '1, 1'b0, '0);
    for (int c = 0; c < 15; c++) begin
      step('0, '0, (c % 5 == 2) ? 8'h10 : 8'h00, '1, 1'b0, '0);
      pulses += int'(trigger_out[4]);
      dones  += int'(done[4]);
    end
    n_cmp++;
    if (pulses != 1 || dones != 1 || busy[4] !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_new_n: pulses/dones/busy=%0d/%0d/%b required 1/1/0", pulses, dones, busy[4]);
    end
  endtask

  task automatic test_async_reset();
    step('0, '0, '0, '1, 1'b1, cfg_one(5, 4));
    step(8'h20, '0, '0, '1, 1'b0, '0);
    step('0, '0, 8'h20, '1, 1'b0, '0);
    step('0, '0, '0, '1, 1'b0, '0);
    n_cmp++;
    if (busy[5] !== 1'b1 || data_out_data[5*BW +: BW] === '0) begin
      n_fail++;
      $display("FAIL rst_pre: busy=%b required 1", busy[5]);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({data_out_valid, trigger_out, busy, done} !== '0 || data_out_data !== '0) begin
      n_fail++;
      $display("FAIL rst_async: valid/trig/busy/done=%h/%h/%h/%h required 0", data_out_valid,
               trigger_out, busy, done);
    end
    arm = '0; abort = '0; trigger_in = '0; cfg_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done !== '0 || busy !== '0) begin
      n_fail++;
      $display("FAIL rst_hold: busy/done=%h/%h required 0/0", busy, done);
    end
    model_reset();
    rst_n = 1'b1;
    step(8'h20, '0, 8'h20, '1, 1'b0, '0);
    n_cmp++;
    if (busy !== '0 || busy !== exp_busy) begin
      n_fail++;
      $display("FAIL rst_ncfg: busy=%h required 0", busy);
    end
  endtask

  task automatic test_random();
    logic [CH*CB-1:0] cd;
    logic [CH-1:0] a, ab, tr, va;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < CH; k++) begin
        cd[k*CB +: CB] = CB'($urandom_range(0, 3));
        a[k]  = ($urandom_range(0, 7) == 0);
        ab[k] = ($urandom_range(0, 31) == 0);
        tr[k] = ($urandom_range(0, 3) == 0);
        va[k] = ($urandom_range(0, 7) != 0);
      end
      step(a, ab, tr, va, $urandom_range(0, 15) == 0, cd);
      n_cmp++;
      if ({data_out_valid, trigger_out, busy, done} !== {exp_valid, exp_trig, exp_busy, exp_done}
          || data_out_data !== exp_data) begin
        n_fail++;
        $display("FAIL random c%0d: valid/trig/busy/done=%h/%h/%h/%h required %h/%h/%h/%h data_ok=%0d",
                 c, data_out_valid, trigger_out, busy, done, exp_valid, exp_trig, exp_busy,
                 exp_done, data_out_data === exp_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_cfg();
    test_arm_trig_same();
    test_abort();
    test_valid_gate();
    test_cfg_update();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
